// File: rtl/soc_intc_pkg.sv
// Shared constants and helpers for the soc_intc interrupt controller.
// The register map offsets are byte offsets within the 256-byte window.
package soc_intc_pkg;

  localparam int MAX_SRC          = 32;
  localparam int ACTIVE_VALID_BIT = 31;

  localparam logic [31:0] INTC_BASE_ADDR = 32'hFFFF_0200;

  localparam logic [7:0] OFS_RAW     = 8'h00;
  localparam logic [7:0] OFS_PENDING = 8'h04;
  localparam logic [7:0] OFS_ENABLE  = 8'h08;
  localparam logic [7:0] OFS_TRIGGER = 8'h0C;
  localparam logic [7:0] OFS_FIQ_SEL = 8'h10;
  localparam logic [7:0] OFS_CLEAR   = 8'h14;
  localparam logic [7:0] OFS_SW_SET  = 8'h18;
  localparam logic [7:0] OFS_ACTIVE  = 8'h1C;

  typedef logic [31:0] word_t;

  // Index bits are forced to zero when nothing is active, so ACTIVE reads 0.
  function automatic word_t activeWord(input logic valid, input logic [4:0] idx);
    word_t w;
    w = '0;
    w[ACTIVE_VALID_BIT] = valid;
    w[4:0] = valid ? idx : 5'd0;
    return w;
  endfunction

endpackage

// File: rtl/soc_intc_bus_if.sv
// Peripheral data-bus bundle shared by UART, GPIO and the interrupt controller.
interface soc_intc_bus_if;
  import soc_intc_pkg::*;

  word_t addr;
  word_t write_data;
  logic  write_en;
  logic  read_en;
  word_t read_data;

  modport master (output addr, output write_data, output write_en, output read_en,
                  input read_data);
  modport slave  (input addr, input write_data, input write_en, input read_en,
                  output read_data);

endinterface

// File: rtl/soc_intc_src_cond.sv
// Per-source conditioning: synchroniser, rising-edge latch and software pending bit.
module soc_intc_src_cond
  import soc_intc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  input  logic trigger_i,
  input  logic clear_i,
  input  logic set_sw_i,
  output logic raw_o,
  output logic pend_o
);

  logic prev_q;
  logic edgeLatch_q, edgeLatch_d;
  logic swPend_q, swPend_d;
  logic rise;

  if (SYNC_STAGES == 0) begin : gNoSync
    assign raw_o = src_i;
  end else begin : gSync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= src_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign raw_o = sync_q[SYNC_STAGES-1];
  end

  // A new edge wins over a simultaneous clear so no event is ever dropped.
  assign rise = raw_o & ~prev_q;

  always_comb begin
    edgeLatch_d = edgeLatch_q;
    swPend_d    = swPend_q;
    if (rise) begin
      edgeLatch_d = 1'b1;
    end else if (clear_i) begin
      edgeLatch_d = 1'b0;
    end
    if (set_sw_i) begin
      swPend_d = 1'b1;
    end else if (clear_i) begin
      swPend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= 1'b0;
      edgeLatch_q <= 1'b0;
      swPend_q    <= 1'b0;
    end else begin
      prev_q      <= raw_o;
      edgeLatch_q <= edgeLatch_d;
      swPend_q    <= swPend_d;
    end
  end

  assign pend_o = (trigger_i ? edgeLatch_q : raw_o) | swPend_q;

endmodule

// File: rtl/soc_intc.sv
// Memory-mapped interrupt controller feeding the CPU irq/fiq inputs.
// Holds mask registers, the priority encoder, registered outputs and the read mux.
module soc_intc
  import soc_intc_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  soc_intc_bus_if.slave      bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq,
  output logic               fiq
);

  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] trigger_q, trigger_d;
  logic [NUM_SRC-1:0] fiqSel_q, fiqSel_d;
  logic [NUM_SRC-1:0] clearVec, swSetVec;
  logic [NUM_SRC-1:0] raw, pend, actIrq, actFiq;
  logic [4:0]         activeIdx;
  word_t              activeVal;
  word_t              readData_q, readData_d;
  logic               irq_q, fiq_q;
  logic [7:0]         ofs;
  logic               unusedBits;

  assign ofs        = {bus.addr[7:2], 2'b00};
  assign unusedBits = ^{bus.addr[31:8], bus.addr[1:0], bus.write_data};

  function automatic word_t zext(input logic [NUM_SRC-1:0] v);
    word_t w;
    w = '0;
    w[NUM_SRC-1:0] = v;
    return w;
  endfunction

  for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
    soc_intc_src_cond #(.SYNC_STAGES(SYNC_STAGES)) uCond (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_i     (irq_src[g]),
      .trigger_i (trigger_q[g]),
      .clear_i   (clearVec[g]),
      .set_sw_i  (swSetVec[g]),
      .raw_o     (raw[g]),
      .pend_o    (pend[g])
    );
  end

  always_comb begin
    enable_d  = enable_q;
    trigger_d = trigger_q;
    fiqSel_d  = fiqSel_q;
    clearVec  = '0;
    swSetVec  = '0;
    if (bus.write_en) begin
      case (ofs)
        OFS_ENABLE:  enable_d  = bus.write_data[NUM_SRC-1:0];
        OFS_TRIGGER: trigger_d = bus.write_data[NUM_SRC-1:0];
        OFS_FIQ_SEL: fiqSel_d  = bus.write_data[NUM_SRC-1:0];
        OFS_CLEAR:   clearVec  = bus.write_data[NUM_SRC-1:0];
        OFS_SW_SET:  swSetVec  = bus.write_data[NUM_SRC-1:0];
        default:     ;
      endcase
    end
  end

  assign actIrq = pend & enable_q & ~fiqSel_q;
  assign actFiq = pend & enable_q & fiqSel_q;

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    activeIdx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (actIrq[i]) begin
        activeIdx = 5'(i);
      end
    end
  end

  assign activeVal = activeWord(|actIrq, activeIdx);

  always_comb begin
    readData_d = readData_q;
    if (bus.read_en) begin
      case (ofs)
        OFS_RAW:     readData_d = zext(raw);
        OFS_PENDING: readData_d = zext(pend);
        OFS_ENABLE:  readData_d = zext(enable_q);
        OFS_TRIGGER: readData_d = zext(trigger_q);
        OFS_FIQ_SEL: readData_d = zext(fiqSel_q);
        OFS_ACTIVE:  readData_d = activeVal;
        default:     readData_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q   <= '0;
      trigger_q  <= '0;
      fiqSel_q   <= '0;
      readData_q <= '0;
      irq_q      <= 1'b0;
      fiq_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      trigger_q  <= trigger_d;
      fiqSel_q   <= fiqSel_d;
      readData_q <= readData_d;
      irq_q      <= |actIrq;
      fiq_q      <= |actFiq;
    end
  end

  assign bus.read_data = readData_q;
  assign irq           = irq_q;
  assign fiq           = fiq_q;

endmodule

// File: doc/soc_intc.md
Name: soc_intc

Overview:
Memory-mapped interrupt controller placed directly upstream of the CPU core's irq/fiq inputs, which the SoC top currently ties to 0.
- Collects peripheral interrupt lines (UART rx/tx, GPIO, spare) and conditions each one as level- or edge-triggered.
- Applies enable and FIQ-routing masks, prioritises, and drives registered irq/fiq.
- Occupies the data-bus window 0xFFFF0200-0xFFFF02FF using the same addr/write_en/read_en/read_data peripheral bus as UART and GPIO.

Parameters:
- NUM_SRC, 8: number of interrupt sources, 1..32; register bits at index NUM_SRC and above read 0 and ignore writes.
- SYNC_STAGES, 2: synchroniser flops per source, 0..3; 0 means raw = source input directly.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- addr  input  32  bus address; only addr[7:2] decoded, block select done at top level
- write_data  input  32  bus write data
- write_en  input  1  write strobe, already qualified by block select
- read_en  input  1  read strobe, already qualified by block select
- read_data  output  32  registered read data
- irq_src  input  NUM_SRC  peripheral interrupt lines, active-high
- irq  output  1  normal interrupt request to CPU, registered
- fiq  output  1  fast interrupt request to CPU, registered

Behaviour:
- Reset (async, rst_n=0): all flops clear; read_data=0, irq=0, fiq=0, ENABLE=0, TRIGGER=0, FIQ_SEL=0, edge latches=0, SW_PEND=0, synchronisers=0, prev-raw=0.
- Register map (offset = addr[7:0]):
  - 0x00 RAW (RO): synchroniser outputs.
  - 0x04 PENDING (RO): see pend below.
  - 0x08 ENABLE (RW).
  - 0x0C TRIGGER (RW): 1 = edge, 0 = level.
  - 0x10 FIQ_SEL (RW): 1 = route to fiq.
  - 0x14 CLEAR (WO, write-1-to-clear edge latches and SW_PEND).
  - 0x18 SW_SET (WO, write-1-to-set SW_PEND).
  - 0x1C ACTIVE (RO).
  - Unmapped offsets read 0; writes to them are ignored. WO registers read 0.
- Read timing: on a clock edge with read_en=1, read_data <= selected register value. read_data holds its value when read_en=0. Data is valid the cycle after the strobe. Reads have no side effects.
- Writes: full-word, take effect on the clock edge with write_en=1. Simultaneous read_en and write_en to the same register returns the pre-write value.
- Source conditioning, per source i:
  - raw[i] = SYNC_STAGES-deep synchroniser of irq_src[i].
  - prev[i] <= raw[i] every cycle.
  - Edge latch sets on a clock edge where raw[i]=1 and prev[i]=0.
  - In the same cycle: set beats CLEAR; CLEAR beats no event.
  - Latch is kept while TRIGGER[i]=0 but ignored. It is not cleared by a mode change.
- pend[i] = (TRIGGER[i] ? edge_latch[i] : raw[i]) | SW_PEND[i]. CLEAR has no effect on the level-raw term.
- Masked vectors:
  - act_irq = pend & ENABLE & ~FIQ_SEL
  - act_fiq = pend & ENABLE & FIQ_SEL
- Outputs: irq <= |act_irq and fiq <= |act_fiq, registered every cycle.
- Latency at SYNC_STAGES=2, counted from the first edge sampling a source high:
  - Level source: irq high after 3 edges.
  - Edge source: irq high after 4 edges.
  - Deassertion latency equals assertion latency.
- ACTIVE: lowest set index of act_irq, with bit31=1 (valid) and bits[4:0]=index; 0 when act_irq=0. Lower index = higher priority. FIQ sources never appear in ACTIVE.
- Mid-operation reset: everything clears immediately, irq/fiq drop asynchronously, and any edge seen before reset is lost.

Decomposition:
- Shared package soc_intc_pkg:
  - register offset constants (OFS_RAW..OFS_ACTIVE);
  - ACTIVE valid-bit position (31);
  - MAX_SRC=32;
  - base address 0xFFFF0200, for top-level decode.
- One sub-module, soc_intc_src_cond, instantiated NUM_SRC times. It contains the synchroniser, prev flop and edge latch, with inputs trigger, clear and set_sw, and outputs raw and pend.
- Top module holds the mask registers, priority encoder, irq/fiq flops and read mux.

Test Plan:
1. Reset, then read all offsets -> every read returns 0x00000000; irq=fiq=0.
2. ENABLE=0x01, TRIGGER=0, hold irq_src[0]=1 -> irq=1 on the 3rd edge; ACTIVE reads 0x80000000. Drop irq_src[0] -> irq=0 3 edges later. CLEAR=0x01 while the source is held high -> irq stays 1.
3. ENABLE=0x04, TRIGGER=0x04, 1-cycle pulse on irq_src[2] -> irq=1 on the 4th edge and stays 1; PENDING=0x04. Write CLEAR=0x04 -> irq=0 the edge after the write. A second pulse arriving on the same edge as the CLEAR write leaves PENDING=0x04.
4. ENABLE=0x30, FIQ_SEL=0x10, level-high sources 4 and 5 -> fiq=1, irq=1; ACTIVE=0x80000005. Set ENABLE=0x10 -> irq=0, fiq stays 1.
5. SW_SET=0x80 with ENABLE=0x80 -> PENDING=0x80, irq=1 on the next edge, ACTIVE=0x80000007. CLEAR=0x80 -> irq=0. Write 0xFFFFFFFF to ENABLE with NUM_SRC=8 -> reads back 0x000000FF.
6. Assert rst_n=0 mid-cycle while irq=1 and an edge latch is set -> irq drops immediately. After release, PENDING=0 and ENABLE=0.
